// File: rtl/cs_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 3-to-8 active-low chip-select decoder.
// Optional forced-release timeout is built only when CS_ARB_TIMEOUT_EN is defined.
module cs_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] sel_idx,
    output logic       sel_en,
    output logic [7:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] ptr_r, ptr_s;
    logic [2:0] sel_idx_r, sel_idx_s;
    logic       sel_en_r, sel_en_s;
    logic [7:0] gnt_n_r, gnt_n_s;
    logic       busy_r, busy_s;
`ifdef CS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic       timeout_r, timeout_s;
`endif

    // First requester at or after p, scanning upward and wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] decode_n(input logic [2:0] idx);
        decode_n = ~(8'b0000_0001 << idx);
    endfunction

    // Next-state and next-output logic; outputs derive from the next state so they can be registered.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_idx_s = sel_idx_r;
`ifdef CS_ARB_TIMEOUT_EN
        hold_cnt_s = hold_cnt_r;
        timeout_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req != 8'h00) begin
                    state_s   = GRANT;
                    sel_idx_s = rr_pick(req, ptr_r);
`ifdef CS_ARB_TIMEOUT_EN
                    hold_cnt_s = 8'd0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!req[sel_idx_r]) begin
                    state_s = GAP;
                    ptr_s   = sel_idx_r + 3'd1;
`ifdef CS_ARB_TIMEOUT_EN
                end else if (hold_cnt_r == 8'(MAX_HOLD - 1)) begin
                    state_s   = GAP;
                    ptr_s     = sel_idx_r + 3'd1;
                    timeout_s = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
`else
                end else begin
                    state_s = GRANT;
`endif
                end
            end
            GAP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        sel_en_s = (state_s == GRANT);
        if (sel_en_s) begin
            gnt_n_s = decode_n(sel_idx_s);
        end else begin
            gnt_n_s = 8'hFF;
        end
        busy_s = (state_s != IDLE);
    end

    // State and registered decoder/grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= 3'd0;
            sel_idx_r <= 3'd0;
            sel_en_r  <= 1'b0;
            gnt_n_r   <= 8'hFF;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            sel_idx_r <= sel_idx_s;
            sel_en_r  <= sel_en_s;
            gnt_n_r   <= gnt_n_s;
            busy_r    <= busy_s;
        end
    end

`ifdef CS_ARB_TIMEOUT_EN
    // Hold counter and one-cycle forced-release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
            timeout_r  <= timeout_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign sel_idx = sel_idx_r;
    assign sel_en  = sel_en_r;
    assign gnt_n   = gnt_n_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Scoreboard bench for cs_rr_arbiter: a cycle model queues expected outputs, a monitor compares on negedge.
module tb_cs_rr_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef CS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
    localparam int EXCL_CYC   = 2;
`else
    localparam bit TIMEOUT_ON = 1'b0;
    localparam int EXCL_CYC   = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel_idx;
    logic       sel_en;
    logic [7:0] gnt_n;
    logic       busy;
    logic       timeout;

    cs_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sel_idx (sel_idx),
        .sel_en  (sel_en),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       en;
        logic [7:0] gnt;
        logic       bsy;
        logic       tout;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // model: phase 0 idle, 1 granted, 2 dead gap
    int   m_phase = 0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_last  = 0;
    int   m_hold  = 0;
    bit   m_tout  = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int idx_of(input logic [7:0] g);
        idx_of = -1;
        for (int i = 0; i < 8; i++) begin
            if (g[i] == 1'b0) idx_of = i;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.idx  = 3'(m_last);
        e.en   = (m_phase == 1);
        e.gnt  = 8'hFF;
        if (m_phase == 1) e.gnt[m_last] = 1'b0;
        e.bsy  = (m_phase != 0);
        e.tout = m_tout;
        return e;
    endfunction

    // Reference model: one expectation per active edge (or reset assertion).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_phase = 0; m_ptr = 0; m_last = 0; m_hold = 0; m_tout = 1'b0;
            end else begin
                m_tout = 1'b0;
                if (m_phase == 0) begin
                    if (req != 8'h00) begin
                        for (int k = 7; k >= 0; k--) begin
                            if (req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                        end
                        m_last  = m_owner;
                        m_hold  = 0;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (!req[m_owner]) begin
                        m_phase = 2;
                        m_ptr   = (m_owner + 1) % 8;
                    end else if (TIMEOUT_ON && m_hold == MAX_HOLD - 1) begin
                        m_phase = 2;
                        m_ptr   = (m_owner + 1) % 8;
                        m_tout  = 1'b1;
                    end else begin
                        m_hold++;
                    end
                end else begin
                    m_phase = 0;
                end
            end
            exp_q.push_back(model_out());
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sel_idx, sel_en, gnt_n, busy, timeout};
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got idx=%0d en=%b gnt_n=%h busy=%b to=%b expected idx=%0d en=%b gnt_n=%h busy=%b to=%b",
                             $time, a.idx, a.en, a.gnt, a.bsy, a.tout, e.idx, e.en, e.gnt, e.bsy, e.tout);
                end
            end
        end
    end

    task automatic wait_grant(input int bound, output int own);
        own = -1;
        for (int c = 0; c < bound && own < 0; c++) begin
            @(negedge clk);
            if (gnt_n != 8'hFF) own = idx_of(gnt_n);
        end
    endtask

    task automatic go_idle();
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int own;
        int cnt;
        int got[$];
        int exp_ord[4] = '{2, 5, 2, 5};
        int gcyc;

        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_gnt_n", int'(gnt_n), 8'hFF);
        chk("reset_sel_en", int'(sel_en), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_gnt_n", int'(gnt_n), 8'hFE);
        chk("first_sel_idx", int'(sel_idx), 0);
        go_idle();

        // rotation between requesters 2 and 5
        req = 8'h24;
        cnt = 0;
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clk);
            if (gnt_n != 8'hFF) begin
                own = idx_of(gnt_n);
                if (cnt == 0) got.push_back(own);
                cnt++;
                if (cnt == 3) req = 8'h24 & ~(8'h01 << own);
            end else begin
                cnt = 0;
                req = 8'h24;
            end
        end
        chk("rotation_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("rotation_order", got[i], exp_ord[i]);
        end
        go_idle();

        // wrap from 7 to 0
        req = 8'h80;
        wait_grant(20, own);
        chk("wrap_first", own, 7);
        req = 8'h00;
        @(negedge clk);
        req = 8'h81;
        wait_grant(10, own);
        chk("wrap_gnt_n", int'(gnt_n), 8'hFE);
        go_idle();

        // hold exclusivity
        req = 8'h08;
        wait_grant(20, own);
        chk("excl_owner", own, 3);
        req = 8'hFF;
        for (int c = 0; c < EXCL_CYC; c++) begin
            @(negedge clk);
            chk("excl_hold", int'(gnt_n), 8'hF7);
        end
        req = 8'hF7;
        wait_grant(10, own);
        chk("excl_next", int'(gnt_n), 8'hEF);
        go_idle();

        // async reset mid-grant
        req = 8'h40;
        wait_grant(20, own);
        chk("areset_owner", own, 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_gnt_n", int'(gnt_n), 8'hFF);
        chk("areset_sel_en", int'(sel_en), 0);
        chk("areset_busy", int'(busy), 0);
        @(negedge clk);
        req   = 8'h41;
        rst_n = 1'b1;
        wait_grant(10, own);
        chk("areset_regrant", int'(gnt_n), 8'hFE);
        go_idle();

        // long hold: forced release with timeout, indefinite hold otherwise
        req = 8'h02;
        wait_grant(20, own);
        chk("hold_owner", own, 1);
`ifdef CS_ARB_TIMEOUT_EN
        gcyc = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt_n == 8'hFF) break;
            gcyc++;
        end
        chk("timeout_grant_cycles", gcyc, MAX_HOLD);
        chk("timeout_pulse", int'(timeout), 1);
        @(negedge clk);
        chk("timeout_single", int'(timeout), 0);
        wait_grant(10, own);
        chk("timeout_regrant", own, 1);
`else
        gcyc = 0;
        repeat (40) @(negedge clk);
        chk("hold_forever_gnt_n", int'(gnt_n), 8'hFD);
        chk("hold_forever_timeout", int'(timeout), 0);
`endif
        go_idle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       req = 8'($urandom);
                1:       req = 8'h00;
                2:       req = req & 8'($urandom);
                default: req = req;
            endcase
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
